// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words, buffered in a 2-entry FIFO and tagged
// with a sequential address. Define ENC_RANGE_CHK_EN to reject out-of-range LW/SW/BLT fields.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    input  logic [11:0]       in_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              full,
    output logic              err,
    output logic [6:0]        err_op
);

    localparam logic [6:0] OpAdd = 7'b0110011;
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpBlt = 7'b1100011;

    localparam logic [ADDR_W:0] IssueOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [31:0]       instr_q [2];
    logic [31:0]       instr_d [2];
    logic [ADDR_W-1:0] addr_q  [2];
    logic [ADDR_W-1:0] addr_d  [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [ADDR_W:0]   issue_q, issue_d;
    logic              err_q, err_d;
    logic [6:0]        err_op_q, err_op_d;

    logic [31:0] enc_word;
    logic        legal;
    logic        fifo_full;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word = '0;
        legal    = 1'b0;
        case (in_op)
            OpAdd: begin
                legal    = 1'b1;
                enc_word = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, in_op};
            end
            OpLw: begin
                legal    = 1'b1;
                enc_word = {12'b0, in_imm[4:0], 3'b010, in_rd, in_op};
            end
            OpSw: begin
                legal    = 1'b1;
                enc_word = {7'b0, in_rs2, in_imm[4:0], 3'b010, 5'b0, in_op};
            end
            OpBlt: begin
                legal    = 1'b1;
                enc_word = {in_offset[11:5], in_rs2, in_rs1, 3'b100, in_offset[4:0], in_op};
            end
            default: begin
                legal    = 1'b0;
                enc_word = '0;
            end
        endcase
`ifdef ENC_RANGE_CHK_EN
        if ((in_op == OpLw || in_op == OpSw) && (in_imm[20:5] != 16'h0)) begin
            legal = 1'b0;
        end
        if (in_op == OpBlt && in_offset[0]) begin
            legal = 1'b0;
        end
`endif
    end

`ifndef ENC_RANGE_CHK_EN
    // Upper immediate bits are truncated by design in this build.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[20:5];
`endif

    assign fifo_full = (occ_q == 2'd2);
    assign full      = issue_q[ADDR_W];
    assign in_ready  = !fifo_full && !full;
    assign out_valid = (occ_q != 2'd0);
    assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
    assign out_addr  = out_valid ? addr_q[rd_ptr_q] : '0;
    assign err       = err_q;
    assign err_op    = err_op_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        instr_d  = instr_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        issue_d  = issue_q;
        err_d    = err_q;
        err_op_d = err_op_q;

        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
            issue_d  = '0;
            err_d    = 1'b0;
            err_op_d = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = enc_word;
                addr_d[wr_ptr_q]  = issue_q[ADDR_W-1:0];
                wr_ptr_d          = ~wr_ptr_q;
                issue_d           = issue_q + IssueOne;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
            // Only the first illegal request since the last clear/reset is recorded.
            if (accept && !legal) begin
                err_d = 1'b1;
                if (!err_q) begin
                    err_op_d = in_op;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '{default: '0};
            addr_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            issue_q  <= '0;
            err_q    <= 1'b0;
            err_op_q <= '0;
        end else begin
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            issue_q  <= issue_d;
            err_q    <= err_d;
            err_op_q <= err_op_d;
        end
    end

endmodule
